// File: rtl/imm_gen_stage.sv
// Decode-stage immediate generator. Extends the selected immediate format
// to XLEN bits on the input side and queues {imm, tag, illegal} in a
// 2-entry valid/ready FIFO with synchronous flush and reset.
module imm_gen_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst,
    input  logic [2:0]       imm_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [XLEN-1:0]   r_imm [2];
    logic [TAG_W-1:0]  r_tag [2];
    logic              r_ill [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;

    logic [XLEN-1:0]   w_imm;
    logic              w_ill;
    logic              w_push;
    logic              w_pop;

    // Format decode and extension; everything is built directly at XLEN so
    // no intermediate bits go unused.  U is formed as sx(inst[31:12]) << 12,
    // which gives the sign-extended-from-bit-31 result for both widths.
    always_comb begin
        w_imm = '0;
        w_ill = 1'b0;
        case (imm_sel)
            3'd0: w_imm = {{(XLEN-12){inst[31]}}, inst[31:20]};
            3'd1: w_imm = {{(XLEN-13){inst[31]}}, inst[31], inst[7],
                           inst[30:25], inst[11:8], 1'b0};
            3'd2: w_imm = {{(XLEN-20){inst[31]}}, inst[31:12]} << 12;
            3'd3: w_imm = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12],
                           inst[20], inst[30:21], 1'b0};
            3'd4: w_imm = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
            3'd5: w_imm = {{(XLEN-5){1'b0}}, inst[19:15]};
            3'd6: w_imm = {{(XLEN-6){1'b0}}, (XLEN == 64) ? inst[25] : 1'b0,
                           inst[24:20]};
            default: begin
                w_imm = '0;
                w_ill = 1'b1;
            end
        endcase
    end

    // Flush wins over both handshakes, so neither side sees a transfer.
    assign w_push = in_valid  & in_ready  & ~flush;
    assign w_pop  = out_valid & out_ready & ~flush;

    // FIFO state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_EMPTY;
        else     r_state <= w_state_nxt;
    end

    // Occupancy transitions; flush empties the buffer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: if (w_push) w_state_nxt = S_ONE;
            S_ONE: begin
                if (w_push && !w_pop)      w_state_nxt = S_FULL;
                else if (w_pop && !w_push) w_state_nxt = S_EMPTY;
            end
            S_FULL:  if (w_pop) w_state_nxt = S_ONE;
            default: w_state_nxt = S_EMPTY;
        endcase
        if (flush) w_state_nxt = S_EMPTY;
    end

    // Handshake and head outputs; data is forced to zero while empty.
    always_comb begin
        in_ready    = !rst && (r_state != S_FULL);
        out_valid   = (r_state != S_EMPTY);
        out_imm     = '0;
        out_tag     = '0;
        out_illegal = 1'b0;
        if (out_valid) begin
            out_imm     = r_imm[r_rd_ptr];
            out_tag     = r_tag[r_rd_ptr];
            out_illegal = r_ill[r_rd_ptr];
        end
    end

    // Entry storage and pointers; flush only rewinds pointers since stale
    // storage is never visible once the state is EMPTY.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_imm[i] <= '0;
                r_tag[i] <= '0;
                r_ill[i] <= 1'b0;
            end
        end else if (flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else begin
            if (w_push) begin
                r_imm[r_wr_ptr] <= w_imm;
                r_tag[r_wr_ptr] <= in_tag;
                r_ill[r_wr_ptr] <= w_ill;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: XLEN=32 and XLEN=64 instances share stimulus;
// a scoreboard queue predicts FIFO contents and handshake state.
module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] inst = '0;
    logic [2:0]  imm_sel = '0;
    logic [4:0]  in_tag = '0;
    logic        out_ready = 1'b0;

    logic        in_ready32, out_valid32, out_ill32;
    logic [31:0] out_imm32;
    logic [4:0]  out_tag32;
    logic        in_ready64, out_valid64, out_ill64;
    logic [63:0] out_imm64;
    logic [4:0]  out_tag64;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] i32;
        logic [63:0] i64;
        logic [4:0]  tag;
        logic        ill;
    } sb_t;
    sb_t q[$];

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(32), .TAG_W(5)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready32), .inst(inst), .imm_sel(imm_sel), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
        .out_tag(out_tag32), .out_illegal(out_ill32)
    );

    imm_gen_stage #(.XLEN(64), .TAG_W(5)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready64), .inst(inst), .imm_sel(imm_sel), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
        .out_tag(out_tag64), .out_illegal(out_ill64)
    );

    // Reference immediate using signed casts of the raw RISC-V fields.
    function automatic logic [63:0] mdl(input logic [31:0] in, input logic [2:0] sel,
                                        input bit x64);
        longint v;
        case (sel)
            3'd0: v = longint'($signed(in[31:20]));
            3'd1: v = longint'($signed({in[31], in[7], in[30:25], in[11:8], 1'b0}));
            3'd2: v = longint'($signed({in[31:12], 12'h000}));
            3'd3: v = longint'($signed({in[31], in[19:12], in[20], in[30:21], 1'b0}));
            3'd4: v = longint'($signed({in[31:25], in[11:7]}));
            3'd5: v = {59'd0, in[19:15]};
            3'd6: v = x64 ? {58'd0, in[25:20]} : {59'd0, in[24:20]};
            default: v = 64'd0;
        endcase
        return x64 ? v : {32'd0, v[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: drive after negedge, check outputs against the
    // scoreboard, then update the scoreboard with the predicted transfers.
    task automatic cyc(input logic iv, input logic [31:0] ins, input logic [2:0] sel,
                       input logic [4:0] tg, input logic ordy, input logic fl,
                       input logic rs);
        logic  exp_rdy, do_push, do_pop;
        logic [63:0] m32;
        sb_t   e;
        @(negedge clk);
        in_valid = iv; inst = ins; imm_sel = sel; in_tag = tg;
        out_ready = ordy; flush = fl; rst = rs;
        #1;
        exp_rdy = !rs && (q.size() < 2);
        chk("in_ready32", {63'd0, in_ready32}, {63'd0, exp_rdy});
        chk("in_ready64", {63'd0, in_ready64}, {63'd0, exp_rdy});
        chk("out_valid32", {63'd0, out_valid32}, {63'd0, q.size() > 0});
        chk("out_valid64", {63'd0, out_valid64}, {63'd0, q.size() > 0});
        if (q.size() > 0) begin
            chk("imm32", {32'd0, out_imm32}, {32'd0, q[0].i32});
            chk("imm64", out_imm64, q[0].i64);
            chk("tag", {59'd0, out_tag32}, {59'd0, q[0].tag});
            chk("tag64", {59'd0, out_tag64}, {59'd0, q[0].tag});
            chk("ill", {63'd0, out_ill32}, {63'd0, q[0].ill});
            chk("ill64", {63'd0, out_ill64}, {63'd0, q[0].ill});
        end else begin
            chk("idle_out32", {26'd0, out_ill32, out_tag32, out_imm32}, 64'd0);
            chk("idle_out64", out_imm64 | {58'd0, out_ill64, out_tag64}, 64'd0);
        end
        do_push = iv && exp_rdy;
        do_pop  = (q.size() > 0) && ordy;
        m32     = mdl(ins, sel, 1'b0);
        e.i32   = m32[31:0];
        e.i64   = mdl(ins, sel, 1'b1);
        e.tag   = tg;
        e.ill   = (sel == 3'd7);
        @(posedge clk);
        if (rs || fl) q.delete();
        else begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(e);
        end
        #1;
    endtask

    initial begin
        // Reset with in_valid high: nothing may be accepted.
        cyc(1, 32'hFFF00093, 3'd0, 5'd1, 1, 0, 1);
        cyc(1, 32'hFFF00093, 3'd0, 5'd1, 1, 0, 1);

        // Directed formats, one per cycle at full throughput.
        cyc(1, 32'hFFF00093, 3'd0, 5'd1, 1, 0, 0);
        chk("I_valid", {63'd0, out_valid32}, 64'd1);
        chk("I_imm32", {32'd0, out_imm32}, 64'h0000_0000_FFFF_FFFF);
        chk("I_imm64", out_imm64, 64'hFFFF_FFFF_FFFF_FFFF);
        cyc(1, 32'hFE000EE3, 3'd1, 5'd2, 1, 0, 0);
        chk("B_imm32", {32'd0, out_imm32}, 64'h0000_0000_FFFF_FFFC);
        cyc(1, 32'h0080006F, 3'd3, 5'd3, 1, 0, 0);
        chk("J_imm32", {32'd0, out_imm32}, 64'h0000_0000_0000_0008);
        cyc(1, 32'h800000B7, 3'd2, 5'd4, 1, 0, 0);
        chk("U_imm64", out_imm64, 64'hFFFF_FFFF_8000_0000);
        chk("U_imm32", {32'd0, out_imm32}, 64'h0000_0000_8000_0000);
        cyc(1, 32'h000FD073, 3'd5, 5'd5, 1, 0, 0);
        chk("Z_imm32", {32'd0, out_imm32}, 64'd31);
        cyc(1, 32'h02500013, 3'd6, 5'd6, 1, 0, 0);
        chk("SH_imm32", {32'd0, out_imm32}, 64'd5);
        chk("SH_imm64", out_imm64, 64'd37);
        cyc(1, 32'hFE112E23, 3'd4, 5'd7, 1, 0, 0);
        chk("S_imm32", {32'd0, out_imm32}, 64'h0000_0000_FFFF_FFFC);
        cyc(1, 32'hFFFFFFFF, 3'd7, 5'd8, 1, 0, 0);
        chk("R_ill", {63'd0, out_ill32}, 64'd1);
        chk("R_imm64", out_imm64, 64'd0);
        cyc(0, 32'h0, 3'd0, 5'd0, 1, 0, 0);
        cyc(0, 32'h0, 3'd0, 5'd0, 1, 0, 0);

        // Backpressure: A, B accepted, C held until space frees up.
        cyc(1, 32'h00100093, 3'd0, 5'd10, 0, 0, 0);
        cyc(1, 32'h00200093, 3'd0, 5'd11, 0, 0, 0);
        chk("bp_full_rdy", {63'd0, in_ready32}, 64'd0);
        cyc(1, 32'h00300093, 3'd0, 5'd12, 0, 0, 0);
        cyc(1, 32'h00300093, 3'd0, 5'd12, 1, 0, 0);
        cyc(1, 32'h00300093, 3'd0, 5'd12, 1, 0, 0);
        cyc(0, 32'h0, 3'd0, 5'd0, 1, 0, 0);
        cyc(0, 32'h0, 3'd0, 5'd0, 1, 0, 0);

        // Flush while FULL with a push attempt.
        cyc(1, 32'h00400093, 3'd0, 5'd13, 0, 0, 0);
        cyc(1, 32'h00500093, 3'd0, 5'd14, 0, 0, 0);
        cyc(1, 32'h00600093, 3'd0, 5'd15, 0, 1, 0);
        chk("flush_valid", {63'd0, out_valid32}, 64'd0);
        chk("flush_rdy", {63'd0, in_ready32}, 64'd1);
        cyc(0, 32'h0, 3'd0, 5'd0, 1, 0, 0);

        // Reset while FULL.
        cyc(1, 32'h00700093, 3'd0, 5'd16, 0, 0, 0);
        cyc(1, 32'h00800093, 3'd0, 5'd17, 0, 0, 0);
        cyc(1, 32'h00900093, 3'd0, 5'd18, 0, 0, 1);
        chk("rst_valid", {63'd0, out_valid32}, 64'd0);
        chk("rst_imm", {32'd0, out_imm32}, 64'd0);

        // Random traffic with occasional flush.
        for (int i = 0; i < 60; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), $urandom, 3'($urandom_range(0, 7)),
                5'($urandom_range(0, 31)), 1'($urandom_range(0, 2) != 0),
                1'($urandom_range(0, 19) == 0), 1'b0);
        end
        cyc(0, 32'h0, 3'd0, 5'd0, 1, 0, 0);
        cyc(0, 32'h0, 3'd0, 5'd0, 1, 0, 0);
        cyc(0, 32'h0, 3'd0, 5'd0, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
